// File: rtl/seq_mem_pkg.sv
// Shared layout and state encodings for the processed-sequence memory image.
// Each entry is two bytes (value, credibility) placed at base + ENTRY_STRIDE*idx.
package seq_mem_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ_VAL  = 3'd1;
    localparam logic [2:0] S_CAP_VAL  = 3'd2;
    localparam logic [2:0] S_CAP_CRED = 3'd3;
    localparam logic [2:0] S_EMIT     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [15:0] ENTRY_STRIDE = 16'd2;
    localparam logic [15:0] VALUE_OFS    = 16'd0;
    localparam logic [15:0] CRED_OFS     = 16'd1;
    localparam logic [7:0]  CRED_MAX     = 8'd31;

    // Byte address of one field of an entry; wraps modulo 2^16.
    function automatic logic [15:0] entry_addr(input logic [15:0] base,
                                               input logic [9:0]  idx,
                                               input logic [15:0] ofs);
        return base + ({6'd0, idx} * ENTRY_STRIDE) + ofs;
    endfunction

endpackage

// File: rtl/sequence_stream_reader.sv
// Fetches K two-byte entries over the byte-wide memory port and streams them out
// on a valid/ready interface, tracking low-credibility entries and illegal credibilities.
module sequence_stream_reader #(
    parameter logic [7:0] CRED_MAX        = seq_mem_pkg::CRED_MAX,
    parameter logic [7:0] LOW_CRED_THRESH = 8'd8
) (
    input  logic        I_CLOCK,
    input  logic        I_RESET,
    input  logic        I_START,
    input  logic [15:0] I_ADD,
    input  logic [9:0]  I_K,
    output logic [15:0] O_MEMORY_ADDRESS,
    output logic        O_MEMORY_ENABLE,
    input  logic [7:0]  I_MEMORY_READ_DATA,
    output logic        O_VALID,
    input  logic        I_READY,
    output logic [7:0]  O_VALUE,
    output logic [7:0]  O_CRED,
    output logic        O_LAST,
    output logic        O_DONE,
    output logic [9:0]  O_LOW_CRED_COUNT,
    output logic        O_ERROR
);
    import seq_mem_pkg::*;

    logic [2:0]  r_state;
    logic [15:0] r_base;
    logic [9:0]  r_k;
    logic [9:0]  r_idx;
    logic [15:0] r_addr;
    logic        r_en;
    logic        r_valid;
    logic [7:0]  r_value;
    logic [7:0]  r_cred;
    logic        r_last;
    logic        r_done;
    logic [9:0]  r_cnt;
    logic        r_err;
    logic [9:0]  w_next_idx;

    assign w_next_idx = r_idx + 10'd1;

    // NOTE: every register, including the latched run parameters, is cleared by the
    // asynchronous reset so an aborted run leaves nothing behind; all state uses <=.
    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_k     <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_en    <= 1'b0;
            r_valid <= 1'b0;
            r_value <= '0;
            r_cred  <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (I_START) begin
                        r_base <= I_ADD;
                        r_k    <= I_K;
                        r_idx  <= '0;
                        r_cnt  <= '0;
                        r_err  <= 1'b0;
                        if (I_K == 10'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= entry_addr(I_ADD, 10'd0, VALUE_OFS);
                            r_en    <= 1'b1;
                            r_state <= S_REQ_VAL;
                        end
                    end
                end
                S_REQ_VAL: begin
                    r_addr  <= entry_addr(r_base, r_idx, CRED_OFS);
                    r_state <= S_CAP_VAL;
                end
                S_CAP_VAL: begin
                    r_value <= I_MEMORY_READ_DATA;
                    r_state <= S_CAP_CRED;
                end
                S_CAP_CRED: begin
                    r_cred <= I_MEMORY_READ_DATA;
                    if (I_MEMORY_READ_DATA < LOW_CRED_THRESH) r_cnt <= r_cnt + 10'd1;
                    if (I_MEMORY_READ_DATA > CRED_MAX)        r_err <= 1'b1;
                    r_en    <= 1'b0;
                    r_valid <= 1'b1;
                    r_last  <= (r_idx == r_k - 10'd1);
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    if (I_READY) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_addr  <= entry_addr(r_base, w_next_idx, VALUE_OFS);
                            r_en    <= 1'b1;
                            r_state <= S_REQ_VAL;
                        end
                    end
                end
                S_DONE: begin
                    r_en   <= 1'b0;
                    r_done <= 1'b1;
                    if (!I_START) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign O_MEMORY_ADDRESS = r_addr;
    assign O_MEMORY_ENABLE  = r_en;
    assign O_VALID          = r_valid;
    assign O_VALUE          = r_value;
    assign O_CRED           = r_cred;
    assign O_LAST           = r_last;
    assign O_DONE           = r_done;
    assign O_LOW_CRED_COUNT = r_cnt;
    assign O_ERROR          = r_err;

endmodule
